debug_cmd_parser: RTL and testbench
===================================

Name: debug_cmd_parser

Overview:
- Sits directly downstream of the debugger's command receiver.
- Consumes its one-byte command stream (debug_command / debug_command_pulse) and turns opcodes, some with an argument byte, into registered control outputs.
- Outputs: a stretched reset request, a brightness-plane enable mask, an RGB channel enable mask and a display freeze flag.
- Replaces ad-hoc single-byte compares in the top level, and adds argument collection, timeout and error accounting.

Parameters:
- TIMEOUT_WIDTH, 22, width of the argument-wait timeout counter.
- TIMEOUT_TICKS, 22'd2272727, clk_in cycles allowed between an opcode and its argument byte (about 45 ms at 50 MHz).
- RESET_PULSE_TICKS, 5'd16, cycles reset_request stays high per 'H'.
- RESET_PULSE_WIDTH, 5, width of the reset-hold counter.

Ports:
- clk_in  input  1  the single block clock (clk_root domain).
- reset  input  1  asynchronous, active-low reset.
- cmd_byte  input  8  received command/argument byte; valid only while cmd_pulse is high.
- cmd_pulse  input  1  single-cycle strobe; cmd_byte is sampled on this edge.
- reset_request  output  1  high for exactly RESET_PULSE_TICKS cycles after an 'H'.
- brightness_enable  output  6  bit-plane enable mask.
- rgb_enable  output  3  channel enable mask, [0]=R [1]=G [2]=B.
- freeze  output  1  display freeze flag, toggled by 'F'.
- parser_busy  output  1  high in WAIT_ARG or RESET_HOLD.
- num_accepted  output  8  count of executed commands, saturating.
- num_errors  output  8  count of rejected bytes and timeouts, saturating.

Behaviour:
- Reset values (async, asserted while reset=0):
  - FSM in IDLE.
  - brightness_enable=6'h3F, rgb_enable=3'h7.
  - freeze, reset_request, parser_busy, num_accepted, num_errors all 0.
  - Timeout and hold counters at 0.
- All outputs are registered.
- IDLE, on cmd_pulse:
  - 'H' (0x48): go to RESET_HOLD, load the hold counter, set reset_request on the next edge, increment num_accepted.
  - 'F' (0x46): toggle freeze and increment num_accepted; both visible 1 cycle after the pulse. Stay in IDLE.
  - 'B' (0x42) or 'C' (0x43): latch the opcode, clear the timeout counter, go to WAIT_ARG.
  - Any other byte: increment num_errors, stay in IDLE.
- WAIT_ARG:
  - On cmd_pulse with opcode 'B': brightness_enable <= cmd_byte[5:0], visible 1 cycle after the argument pulse.
  - On cmd_pulse with opcode 'C': rgb_enable <= cmd_byte[2:0], visible 1 cycle after the argument pulse.
  - In both cases the argument byte is taken raw: any value, including 'H', is data, never an opcode. Increment num_accepted and return to IDLE.
  - Each cycle without a pulse, the timeout counter increments.
  - When the counter equals TIMEOUT_TICKS-1 with no pulse: increment num_errors, return to IDLE, leave the target output unchanged.
  - If a pulse arrives in that same cycle, the pulse wins and the argument is accepted.
- RESET_HOLD:
  - reset_request stays high for RESET_PULSE_TICKS cycles, then drops and the FSM returns to IDLE.
  - cmd_pulse here is dropped silently: no counters change.
  - The hold is not retriggered.
- parser_busy = (state != IDLE), registered with the state.
- Counters saturate at 8'hFF and never wrap.
- Asserting reset in any state returns everything to its reset values immediately, including mid-argument and mid-hold.
- This block does not synchronise cmd_pulse; it must come from the clk_in domain.

Optional Feature:
- Macro: DEBUG_CMD_ECHO_EN.
- When defined, two extra outputs exist:
  - echo_byte [7:0]
  - echo_valid [1]
- echo_valid pulses for one cycle, 1 cycle after each event:
  - Executed command: echo_byte is the opcode.
  - Error (unknown byte or timeout): echo_byte is 0x3F '?'.
- Both reset to 0.
- When the macro is undefined, these ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Release reset, pulse 'B' then 0x15 five cycles later -> brightness_enable=6'h15 one cycle after the second pulse; num_accepted=1; parser_busy high only between the two pulses.
- Pulse 'C' then no further pulses (TIMEOUT_TICKS overridden to 20) -> return to IDLE after 20 cycles; num_errors=1; rgb_enable remains 3'h7.
- Pulse 'H', then pulse 'F' 3 cycles later -> reset_request high for exactly 16 cycles; the 'F' is ignored (freeze=0, num_accepted=1, num_errors=0).
- Pulse 'C' then argument 0x48 ('H') -> rgb_enable=3'b000 and reset_request never asserts.
- Send 300 pulses of 0x00 -> num_errors saturates at 8'hFF; with DEBUG_CMD_ECHO_EN, each produces echo_valid with echo_byte=0x3F.
- Assert reset while in WAIT_ARG after 'B' -> all outputs at reset values; a following 0x05 pulse is counted as an error, not applied as an argument.

Source files
------------

// File: rtl/debug_cmd_parser.sv
// Debug command parser: turns the one-byte command stream into registered
// control outputs. Optional echo channel enabled by `define DEBUG_CMD_ECHO_EN.
module debug_cmd_parser #(
  parameter int                         TIMEOUT_WIDTH     = 22,
  parameter logic [TIMEOUT_WIDTH-1:0]   TIMEOUT_TICKS     = 22'd2272727,
  parameter int                         RESET_PULSE_WIDTH = 5,
  parameter logic [RESET_PULSE_WIDTH-1:0] RESET_PULSE_TICKS = 5'd16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_pulse,
  output logic       reset_request,
  output logic [5:0] brightness_enable,
  output logic [2:0] rgb_enable,
  output logic       freeze,
  output logic       parser_busy,
  output logic [7:0] num_accepted,
  output logic [7:0] num_errors,
`ifdef DEBUG_CMD_ECHO_EN
  output logic [7:0] echo_byte,
  output logic       echo_valid,
`endif
  output logic [1:0] state_dbg
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_ARG   = 2'd1;
  localparam logic [1:0] ST_RESET_HOLD = 2'd2;

  localparam logic [7:0] OP_H     = 8'h48;
  localparam logic [7:0] OP_F     = 8'h46;
  localparam logic [7:0] OP_B     = 8'h42;
  localparam logic [7:0] OP_C     = 8'h43;
  localparam logic [7:0] ECHO_ERR = 8'h3F;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    TIMEOUT_TICKS - {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RESET_PULSE_WIDTH-1:0] HOLD_LOAD =
    RESET_PULSE_TICKS - {{(RESET_PULSE_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                   state;
  logic [7:0]                   opcode;
  logic [TIMEOUT_WIDTH-1:0]     timeout_cnt;
  logic [RESET_PULSE_WIDTH-1:0] hold_cnt;

  assign state_dbg = state;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Handshake: cmd_byte is meaningful only in a cycle where cmd_pulse is high;
  // there is no back-pressure, so a pulse during RESET_HOLD is simply dropped.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      opcode            <= 8'h00;
      timeout_cnt       <= '0;
      hold_cnt          <= '0;
      reset_request     <= 1'b0;
      brightness_enable <= 6'h3F;
      rgb_enable        <= 3'h7;
      freeze            <= 1'b0;
      parser_busy       <= 1'b0;
      num_accepted      <= 8'h00;
      num_errors        <= 8'h00;
`ifdef DEBUG_CMD_ECHO_EN
      echo_byte         <= 8'h00;
      echo_valid        <= 1'b0;
`endif
    end else begin
`ifdef DEBUG_CMD_ECHO_EN
      echo_valid <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (cmd_pulse) begin
            case (cmd_byte)
              OP_H: begin
                state         <= ST_RESET_HOLD;
                parser_busy   <= 1'b1;
                hold_cnt      <= HOLD_LOAD;
                reset_request <= 1'b1;
                num_accepted  <= sat_inc(num_accepted);
`ifdef DEBUG_CMD_ECHO_EN
                echo_byte     <= OP_H;
                echo_valid    <= 1'b1;
`endif
              end
              OP_F: begin
                freeze       <= ~freeze;
                num_accepted <= sat_inc(num_accepted);
`ifdef DEBUG_CMD_ECHO_EN
                echo_byte    <= OP_F;
                echo_valid   <= 1'b1;
`endif
              end
              OP_B, OP_C: begin
                opcode      <= cmd_byte;
                timeout_cnt <= '0;
                state       <= ST_WAIT_ARG;
                parser_busy <= 1'b1;
              end
              default: begin
                num_errors <= sat_inc(num_errors);
`ifdef DEBUG_CMD_ECHO_EN
                echo_byte  <= ECHO_ERR;
                echo_valid <= 1'b1;
`endif
              end
            endcase
          end
        end

        ST_WAIT_ARG: begin
          // A pulse in the final timeout cycle still wins over the timeout.
          if (cmd_pulse) begin
            if (opcode == OP_B) brightness_enable <= cmd_byte[5:0];
            else                rgb_enable        <= cmd_byte[2:0];
            num_accepted <= sat_inc(num_accepted);
            state        <= ST_IDLE;
            parser_busy  <= 1'b0;
`ifdef DEBUG_CMD_ECHO_EN
            echo_byte    <= opcode;
            echo_valid   <= 1'b1;
`endif
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            num_errors  <= sat_inc(num_errors);
            state       <= ST_IDLE;
            parser_busy <= 1'b0;
`ifdef DEBUG_CMD_ECHO_EN
            echo_byte   <= ECHO_ERR;
            echo_valid  <= 1'b1;
`endif
          end else begin
            timeout_cnt <= timeout_cnt + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
          end
        end

        ST_RESET_HOLD: begin
          if (hold_cnt == '0) begin
            reset_request <= 1'b0;
            state         <= ST_IDLE;
            parser_busy   <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - {{(RESET_PULSE_WIDTH-1){1'b0}}, 1'b1};
          end
        end

        default: begin
          state         <= ST_IDLE;
          parser_busy   <= 1'b0;
          reset_request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_cmd_parser.sv
// Directed bench for debug_cmd_parser with a short argument timeout (20 ticks).
module tb_debug_cmd_parser;

  logic       clk_in;
  logic       reset;
  logic [7:0] cmd_byte;
  logic       cmd_pulse;
  logic       reset_request;
  logic [5:0] brightness_enable;
  logic [2:0] rgb_enable;
  logic       freeze;
  logic       parser_busy;
  logic [7:0] num_accepted;
  logic [7:0] num_errors;
  logic [1:0] state_dbg;
`ifdef DEBUG_CMD_ECHO_EN
  logic [7:0] echo_byte;
  logic       echo_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  debug_cmd_parser #(
    .TIMEOUT_WIDTH(22),
    .TIMEOUT_TICKS(22'd20),
    .RESET_PULSE_WIDTH(5),
    .RESET_PULSE_TICKS(5'd16)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .cmd_byte(cmd_byte),
    .cmd_pulse(cmd_pulse),
    .reset_request(reset_request),
    .brightness_enable(brightness_enable),
    .rgb_enable(rgb_enable),
    .freeze(freeze),
    .parser_busy(parser_busy),
    .num_accepted(num_accepted),
    .num_errors(num_errors),
`ifdef DEBUG_CMD_ECHO_EN
    .echo_byte(echo_byte),
    .echo_valid(echo_valid),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  {30'd0, state_dbg}, 32'd0);
    check({tag, "_bright"}, {26'd0, brightness_enable}, 32'h3F);
    check({tag, "_rgb"},    {29'd0, rgb_enable}, 32'h7);
    check({tag, "_misc"},   {29'd0, freeze, reset_request, parser_busy}, 32'd0);
    check({tag, "_cnts"},   {16'd0, num_accepted, num_errors}, 32'd0);
  endtask

  // driver tasks: inputs change on the falling edge, outputs read there too
  task automatic apply_reset();
    @(negedge clk_in);
    reset     = 1'b0;
    cmd_pulse = 1'b0;
    #1;
    check_reset_values("reset");
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    cmd_byte  = b;
    cmd_pulse = 1'b1;
    @(negedge clk_in);
    cmd_pulse = 1'b0;
    cmd_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  int hi_cnt;
  logic rr_seen;

  initial begin
    reset     = 1'b0;
    cmd_byte  = 8'h00;
    cmd_pulse = 1'b0;
    apply_reset();

    // 'B' then argument 0x15 five cycles later
    @(negedge clk_in);
    send(8'h42);
    check("b_busy_after_op", {31'd0, parser_busy}, 32'd1);
    idle(4);
    check("b_busy_waiting", {31'd0, parser_busy}, 32'd1);
    send(8'h15);
    check("b_bright", {26'd0, brightness_enable}, 32'h15);
    check("b_accepted", {24'd0, num_accepted}, 32'd1);
    check("b_busy_done", {31'd0, parser_busy}, 32'd0);
    check("b_rgb_kept", {29'd0, rgb_enable}, 32'h7);

    // 'C' with no argument -> timeout after 20 cycles
    apply_reset();
    send(8'h43);
    idle(19);
    check("to_busy_19", {31'd0, parser_busy}, 32'd1);
    idle(1);
    check("to_busy_20", {31'd0, parser_busy}, 32'd0);
    check("to_state", {30'd0, state_dbg}, 32'd0);
    check("to_errors", {24'd0, num_errors}, 32'd1);
    check("to_rgb_kept", {29'd0, rgb_enable}, 32'h7);
    check("to_accepted", {24'd0, num_accepted}, 32'd0);

    // argument arriving in the last timeout cycle is accepted
    apply_reset();
    send(8'h43);
    idle(19);
    send(8'h02);
    check("edge_rgb", {29'd0, rgb_enable}, 32'h2);
    check("edge_errors", {24'd0, num_errors}, 32'd0);
    check("edge_accepted", {24'd0, num_accepted}, 32'd1);

    // 'H' then 'F' three cycles later: 16-cycle pulse, 'F' dropped
    apply_reset();
    send(8'h48);
    hi_cnt = reset_request ? 1 : 0;
    check("h_busy", {31'd0, parser_busy}, 32'd1);
    for (int i = 1; i < 30; i++) begin
      if (i == 3) begin
        cmd_byte  = 8'h46;
        cmd_pulse = 1'b1;
      end else begin
        cmd_pulse = 1'b0;
        cmd_byte  = 8'h00;
      end
      @(negedge clk_in);
      if (reset_request) hi_cnt++;
    end
    check("h_pulse_len", hi_cnt, 32'd16);
    check("h_freeze", {31'd0, freeze}, 32'd0);
    check("h_accepted", {24'd0, num_accepted}, 32'd1);
    check("h_errors", {24'd0, num_errors}, 32'd0);
    check("h_idle", {30'd0, state_dbg}, 32'd0);

    // 'F' toggles freeze
    send(8'h46);
    check("f_freeze_on", {31'd0, freeze}, 32'd1);
`ifdef DEBUG_CMD_ECHO_EN
    check("f_echo", {23'd0, echo_valid, echo_byte}, {23'd0, 1'b1, 8'h46});
`endif
    send(8'h46);
    check("f_freeze_off", {31'd0, freeze}, 32'd0);
    check("f_accepted", {24'd0, num_accepted}, 32'd3);

    // 'C' with argument 'H' is data: rgb=0, no reset request
    apply_reset();
    send(8'h43);
    send(8'h48);
    rr_seen = reset_request;
    check("ch_rgb", {29'd0, rgb_enable}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      rr_seen = rr_seen | reset_request;
    end
    check("ch_no_rr", {31'd0, rr_seen}, 32'd0);
    check("ch_state", {30'd0, state_dbg}, 32'd0);
    check("ch_accepted", {24'd0, num_accepted}, 32'd1);

    // 300 unknown bytes -> error counter saturates
    apply_reset();
    for (int i = 0; i < 300; i++) exp_q.push_back((i < 254) ? 8'(i + 1) : 8'hFF);
    for (int i = 0; i < 300; i++) begin
      send(8'h00);
      check("sat_errors", {24'd0, num_errors}, {24'd0, exp_q.pop_front()});
`ifdef DEBUG_CMD_ECHO_EN
      check("sat_echo", {23'd0, echo_valid, echo_byte}, {23'd0, 1'b1, 8'h3F});
`endif
    end
    check("sat_accepted", {24'd0, num_accepted}, 32'd0);

    // reset while waiting for 'B' argument
    apply_reset();
    send(8'h42);
    check("rw_busy", {31'd0, parser_busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("rw_async");
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    send(8'h05);
    check("rw_errors", {24'd0, num_errors}, 32'd1);
    check("rw_bright", {26'd0, brightness_enable}, 32'h3F);
    check("rw_accepted", {24'd0, num_accepted}, 32'd0);
    check("rw_state", {30'd0, state_dbg}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
